// File: rtl/f5_truth_scanner.sv
// f5_truth_scanner: on-chip stimulus/capture sweep around the f5 decoder block.
// Drives the disabled step, then all 16 enabled codes, samples f at the end of
// each step, and compares the assembled truth vector against an expected one.
module f5_truth_scanner #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f,
  output logic        c,
  output logic        d,
  output logic        c1,
  output logic        d1,
  output logic        en,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth,
  output logic        dis_f,
  output logic        pass
);

  // A settle time of 0 would leave no cycle for f5 to respond, so it acts as 1.
  localparam int              SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIS,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      truth_q, truth_d;
  logic             dis_f_q, dis_f_d;
  logic             pass_q, pass_d;
  logic [15:0]      exp_q, exp_d;
  logic             step_end;

  // The counter runs down from SETTLE-1; zero marks the last cycle of a step,
  // which is the cycle whose closing edge samples f.
  assign step_end = (cnt_q == '0);

  // Next-state, drive and capture logic for the sweep controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    truth_d = truth_q;
    dis_f_d = dis_f_q;
    pass_d  = pass_q;
    exp_d   = exp_q;

    case (state_q)
      S_IDLE: begin
        en_d   = 1'b0;
        code_d = 4'd0;
        if (start) begin
          exp_d   = expected;
          truth_d = 16'd0;
          dis_f_d = 1'b0;
          pass_d  = 1'b0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = S_DIS;
        end
      end

      S_DIS: begin
        if (step_end) begin
          // With en low, a healthy f5 must hold f at 0.
          dis_f_d = f;
          en_d    = 1'b1;
          code_d  = 4'd0;
          cnt_d   = CNT_LOAD;
          state_d = S_SCAN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_SCAN: begin
        if (step_end) begin
          truth_d[code_q] = f;
          cnt_d           = CNT_LOAD;
          if (code_q == 4'hF) begin
            // Final sample: compare using the vector including this last bit.
            en_d    = 1'b0;
            code_d  = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (truth_d == exp_q) && !dis_f_q;
            state_d = S_DONE;
          end else begin
            code_d = code_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        en_d    = 1'b0;
        code_d  = 4'd0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset clears everything so no partial sweep survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      code_q  <= 4'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      truth_q <= 16'd0;
      dis_f_q <= 1'b0;
      pass_q  <= 1'b0;
      exp_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      truth_q <= truth_d;
      dis_f_q <= dis_f_d;
      pass_q  <= pass_d;
      exp_q   <= exp_d;
    end
  end

  // Code bit order into f5: c is the LSB, d1 the MSB.
  assign c     = code_q[0];
  assign d     = code_q[1];
  assign c1    = code_q[2];
  assign d1    = code_q[3];
  assign en    = en_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign truth = truth_q;
  assign dis_f = dis_f_q;
  assign pass  = pass_q;

endmodule
